dn_ram_arbiter: RTL

DN_RAM_ARBITER -- requirements
Module: dn_ram_arbiter

---
 rtl/dn_ram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dn_ram_arbiter.sv
// Shares one byte-wide RAM port between the ioctl download stream and a
// CPU request/ack port; grants alternate when both sides are waiting.
module dn_ram_arbiter #(
    parameter logic [7:0] INDEX  = 8'd0,
    parameter int         ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] dn_count,
    output logic              dn_done,
    output logic              err_range
);

    typedef enum logic [2:0] {
        IDLE, DN_WR, CPU_WR, CPU_RD, CPU_RDW, CPU_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              last_dn_q, last_dn_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic [ADDR_W-1:0] dn_count_q, dn_count_d;
    logic              err_q, err_d;
    logic              dn_active_q, dn_active_d;
    logic              dl_q;
    logic              wr_acc, addr_oor, dl_rise;

    assign wr_acc   = ioctl_wr && (ioctl_index == INDEX);
    assign addr_oor = (ioctl_addr >> ADDR_W) != 25'd0;
    assign dl_rise  = ioctl_download && !dl_q;

    always_comb begin
        state_d   = state_q;
        last_dn_d = last_dn_q;
        unique case (state_q)
            IDLE: begin
                if (buf_valid_q && !(cpu_req && last_dn_q)) begin
                    state_d   = DN_WR;
                    last_dn_d = 1'b1;
                end else if (cpu_req) begin
                    state_d   = cpu_we ? CPU_WR : CPU_RD;
                    last_dn_d = 1'b0;
                end
            end
            DN_WR:    state_d = IDLE;
            CPU_WR:   state_d = CPU_DONE;
            CPU_RD:   state_d = CPU_RDW;
            CPU_RDW:  state_d = CPU_DONE;
            CPU_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The buffer is released as DN_WR is entered; the address/data
    // registers keep feeding the RAM during the DN_WR cycle itself.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        err_d       = err_q;
        if (state_d == DN_WR) buf_valid_d = 1'b0;
        if (dl_rise) err_d = 1'b0;
        if (wr_acc) begin
            if (addr_oor || buf_valid_q) begin
                err_d = 1'b1;
            end else begin
                buf_valid_d = 1'b1;
                buf_addr_d  = ioctl_addr[ADDR_W-1:0];
                buf_data_d  = ioctl_dout;
            end
        end
    end

    always_comb begin
        dn_count_d = dn_count_q;
        if (state_q == DN_WR && dn_count_q != '1) dn_count_d = dn_count_q + 1'b1;
        if (dl_rise) dn_count_d = '0;
        cpu_dout_d  = (state_q == CPU_RDW) ? ram_dout : cpu_dout_q;
        dn_active_d = ioctl_download ? 1'b1 : (dn_done ? 1'b0 : dn_active_q);
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = 8'd0;
        case (state_q)
            DN_WR: begin
                ram_we   = 1'b1;
                ram_addr = buf_addr_q;
                ram_din  = buf_data_q;
            end
            CPU_WR: begin
                ram_we   = 1'b1;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
            end
            CPU_RD, CPU_RDW: ram_addr = cpu_addr;
            default: ;
        endcase
    end

    assign ioctl_wait = buf_valid_q;
    assign cpu_ack    = (state_q == CPU_DONE);
    assign cpu_dout   = cpu_dout_q;
    assign dn_count   = dn_count_q;
    assign err_range  = err_q;
    assign dn_done    = !ioctl_download && dn_active_q && !buf_valid_q
                        && (state_q != DN_WR);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 8'd0;
            last_dn_q   <= 1'b0;
            cpu_dout_q  <= 8'd0;
            dn_count_q  <= '0;
            err_q       <= 1'b0;
            dn_active_q <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            last_dn_q   <= last_dn_d;
            cpu_dout_q  <= cpu_dout_d;
            dn_count_q  <= dn_count_d;
            err_q       <= err_d;
            dn_active_q <= dn_active_d;
            dl_q        <= ioctl_download;
        end
    end

endmodule
